sccb_gpio_sequencer: RTL and testbench
======================================

# sccb_gpio_sequencer

Autonomous APB master that performs SCCB 3-phase write transactions (device ID, sub-address, data) by sequencing a 2-bit CoreGPIO instance's output register. GPIO bit 0 drives SIO_C and bit 1 drives SIO_D. The block sits between the camera-configuration command source and the CoreGPIO APB slave port, so software issues one command per camera register instead of bit-banging.

## Interface
Parameters:
- HALF_CYC, 250: PCLK cycles held after each GPIO_OUT write; 250 gives 100 kHz SCCB at 50 MHz. Legal values are ≥2.
- GPIO_OUT_ADDR, 8'hA0: APB offset of the GPIO_OUT register.
- GPIO_IN_ADDR, 8'h90: APB offset of the GPIO_IN register.

Ports:
- PCLK  in  1  clock. One clock domain; reset is synchronous and active-high.
- PRESET  in  1  synchronous active-high reset.
- start  in  1  one-cycle command strobe.
- dev_addr  in  8  SCCB ID byte, including the write bit.
- reg_addr  in  8  sub-address byte.
- wr_data  in  8  data byte.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 means the transaction was aborted.
- PADDR  out  8  APB address.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PWDATA  out  32  APB write data; bits [31:2] are always 0.
- PRDATA  in  32  APB read data.
- PREADY, PSLVERR  in  1 each  APB completion and error.

## Operation
- States: IDLE, SETUP, ACCESS, WAIT, READ_SETUP, READ_ACCESS, DONE. READ_SETUP and READ_ACCESS exist only with the Configuration macro.
- In IDLE, start latches the three bytes into a 27-bit shift image: {dev,1,reg,1,data,1}. Each appended 1 is the 9th (don't-care) bit, with SIO_D driven high. The block then enters SETUP and asserts busy.
- The step index runs 0..58 and selects the GPIO_OUT value written at each step, encoded as {D,C}:
  - START steps: 2'b11, then 2'b01.
  - Each of the 27 bits b, MSB first: {b,0}, then {b,1}.
  - STOP steps: 2'b00, then 2'b01, then 2'b11.
- Each step is one APB write to GPIO_OUT_ADDR, followed by WAIT for HALF_CYC cycles. After the WAIT of step 58 the block enters DONE.
- DONE: done=1 and err=0 for one cycle, then return to IDLE.
- start while busy=1 is ignored; the latched command is unchanged.
- PSLVERR=1 on any completed transfer aborts the transaction:
  - the next state is DONE with err=1;
  - no further APB transfers are issued;
  - no STOP sequence is sent.
- PRDATA is ignored unless the Configuration macro is defined.

## Timing
- Reset values: busy=0, done=0, err=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. The state is IDLE and the step index is 0.
- PRESET mid-transaction: all outputs return to their reset values on the next edge and the in-flight APB transfer is dropped. The GPIO pins are left at their last written value.
- start sampled at edge N: SETUP is active in cycle N+1, with PSEL=1, PENABLE=0, PWRITE=1, address and data valid. busy=1 from cycle N+1.
- ACCESS: PENABLE=1. The block holds PADDR, PWDATA and PWRITE stable until PREADY=1. The transfer completes at the edge where PSEL·PENABLE·PREADY=1.
- After completion the block drops PSEL and PENABLE and enters WAIT for exactly HALF_CYC cycles. The next SETUP follows immediately.
- With PREADY tied high, each step takes 2+HALF_CYC cycles.
- A complete transaction takes 59×(2+HALF_CYC)+1 cycles from start to the done pulse.
- busy falls in the cycle after done.
- The WAIT counter has width $clog2(HALF_CYC+1). The step counter is 6 bits and never wraps; the terminal value is 58.

## Configuration
- The macro is SCCB_SEQ_READBACK_EN.
- Defined: after every write whose C bit is 1, the block issues an APB read of GPIO_IN_ADDR before WAIT.
  - The read adds 2 or more cycles to that step.
  - It compares PRDATA[1:0] with the written value.
  - On a mismatch the transaction aborts as for PSLVERR (done=1, err=1). This catches a stuck or contended bus.
- Undefined: no reads are issued, and PRDATA, READ_SETUP and READ_ACCESS are absent.

## Structure
- Package sccb_seq_pkg contains:
  - the state enum;
  - the GPIO_OUT_ADDR and GPIO_IN_ADDR defaults;
  - the SIO_C/SIO_D bit indices (0 and 1);
  - the step count constant (59) and the bit count constant (27).
- Sub-module apb_master_xfer performs a single-transfer APB master handshake:
  - request and completion strobes;
  - err output;
  - read data capture.
- The sequencer FSM owns stepping, the shift image and the WAIT counter.

## Test plan
- Nominal transaction: HALF_CYC=4, PREADY=1, start with dev=8'h42, reg=8'h12, data=8'h80. The bench must see exactly 59 writes, all to 8'hA0, with PWDATA sequence 3,1, then bit pairs for 0x42/1/0x12/1/0x80/1, then 0,1,3. done=1 with err=0 at cycle 59×6+1 after start.
- PREADY stall: hold PREADY low for 3 cycles on write #5. PADDR and PWDATA stay stable, no duplicate transfer occurs, and the total length grows by exactly 3.
- PSLVERR=1 on write #10: done=1 and err=1 on the next cycle, no further PSEL, and busy=0 afterwards.
- Start pulses during a busy transaction: pulse start with different bytes at cycles 20 and 200. The output sequence is identical to the nominal case and only one done is produced.
- Reset mid-transaction: assert PRESET at step 30. All outputs are 0 on the next edge. A new start then produces a full 59-write sequence from step 0.
- Readback, with SCCB_SEQ_READBACK_EN: the GPIO model returns 2'b00 on the read after write #4 (value 2'b01). Read transfers to 8'h90 are observed, and done=1 with err=1 follows that read.

Source files
------------

// File: rtl/sccb_seq_pkg.sv
// Shared types and constants for the SCCB-over-CoreGPIO sequencer.
// SCCB_SEQ_READBACK_EN adds the GPIO_IN readback states.
package sccb_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT,
`ifdef SCCB_SEQ_READBACK_EN
    ST_READ_SETUP,
    ST_READ_ACCESS,
`endif
    ST_DONE
  } seq_state_e;

  localparam logic [7:0] DEF_GPIO_OUT_ADDR = 8'hA0;
  localparam logic [7:0] DEF_GPIO_IN_ADDR  = 8'h90;

  localparam int SIO_C_BIT = 0;
  localparam int SIO_D_BIT = 1;

  localparam int NUM_STEPS = 59;
  localparam int NUM_BITS  = 27;

  localparam logic [5:0] LAST_STEP = 6'(NUM_STEPS - 1);
  localparam logic [5:0] STOP_STEP = 6'(2 + 2 * NUM_BITS);

  // GPIO_OUT value for a given step: START pair, two steps per bit, STOP triple.
  function automatic logic [1:0] step_val(input logic [5:0] step,
                                          input logic [NUM_BITS-1:0] img);
    logic [1:0] v;
    logic [5:0] rel;
    logic       d;
    logic       c;
    rel = step - 6'd2;
    if (step == 6'd0) begin
      d = 1'b1; c = 1'b1;
    end else if (step == 6'd1) begin
      d = 1'b0; c = 1'b1;
    end else if (step < STOP_STEP) begin
      d = img[5'(NUM_BITS - 1) - rel[5:1]];
      c = rel[0];
    end else if (step == STOP_STEP) begin
      d = 1'b0; c = 1'b0;
    end else if (step == STOP_STEP + 6'd1) begin
      d = 1'b0; c = 1'b1;
    end else begin
      d = 1'b1; c = 1'b1;
    end
    v = 2'b00;
    v[SIO_D_BIT] = d;
    v[SIO_C_BIT] = c;
    return v;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Single-transfer APB master: a request strobe launches SETUP, cpl_o marks the completing edge.
// SCCB_SEQ_READBACK_EN adds read data capture.
module apb_master_xfer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
`ifdef SCCB_SEQ_READBACK_EN
  input  logic [31:0] prdata_i,
  output logic [31:0] rdata_o,
`endif
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [7:0]  paddr_o,
  output logic [31:0] pwdata_o,
  output logic        cpl_o,
  output logic        err_o
);

  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [7:0]  paddr_q;
  logic [31:0] pwdata_q;

  assign cpl_o = psel_q & penable_q & pready_i;
  assign err_o = cpl_o & pslverr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (req_i) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      pwrite_q  <= write_i;
      paddr_q   <= addr_i;
      pwdata_q  <= wdata_i;
    end else if (cpl_o) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else if (psel_q) begin
      penable_q <= 1'b1;
    end
  end

`ifdef SCCB_SEQ_READBACK_EN
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else if (cpl_o && !pwrite_q) rdata_q <= prdata_i;
  end

  // Bypass so the caller can act on the completing edge itself.
  assign rdata_o = (cpl_o && !pwrite_q) ? prdata_i : rdata_q;
`endif

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/sccb_gpio_sequencer.sv
// SCCB 3-phase write engine driving SIO_C/SIO_D through a CoreGPIO output register.
// SCCB_SEQ_READBACK_EN enables GPIO_IN readback after every SIO_C-high write.
module sccb_gpio_sequencer
  import sccb_seq_pkg::*;
#(
  parameter int         HALF_CYC      = 250,
  parameter logic [7:0] GPIO_OUT_ADDR = DEF_GPIO_OUT_ADDR,
  parameter logic [7:0] GPIO_IN_ADDR  = DEF_GPIO_IN_ADDR
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic [7:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [7:0]  wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
`ifdef SCCB_SEQ_READBACK_EN
  input  logic [31:0] PRDATA,
`endif
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int             CW       = $clog2(HALF_CYC + 1);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(HALF_CYC - 1);

  seq_state_e          state_q, state_d;
  logic [5:0]          step_q, step_d;
  logic [NUM_BITS-1:0] img_q, img_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;

  logic       req;
  logic       req_write;
  logic [1:0] req_val;
  logic [1:0] cur_val;
  logic       cpl;
  logic       xfer_err;
`ifdef SCCB_SEQ_READBACK_EN
  logic [31:0] rdata;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      img_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      img_q   <= img_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    img_d     = img_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req       = 1'b0;
    req_write = 1'b1;
    cur_val   = step_val(step_q, img_q);
    req_val   = cur_val;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          img_d   = {dev_addr, 1'b1, reg_addr, 1'b1, wr_data, 1'b1};
          step_d  = '0;
          err_d   = 1'b0;
          req     = 1'b1;
          req_val = step_val(6'd0, img_d);
          state_d = ST_SETUP;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (cpl) begin
          if (xfer_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
`ifdef SCCB_SEQ_READBACK_EN
          else if (cur_val[SIO_C_BIT]) begin
            req       = 1'b1;
            req_write = 1'b0;
            state_d   = ST_READ_SETUP;
          end
`endif
          else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
`ifdef SCCB_SEQ_READBACK_EN
      ST_READ_SETUP: state_d = ST_READ_ACCESS;
      ST_READ_ACCESS: begin
        if (cpl) begin
          if (xfer_err || (rdata[1:0] != cur_val)) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
`endif
      ST_WAIT: begin
        if (cnt_q == '0) begin
          if (step_q == LAST_STEP) begin
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + 6'd1;
            req     = 1'b1;
            req_val = step_val(step_d, img_q);
            state_d = ST_SETUP;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  apb_master_xfer u_xfer (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .req_i     (req),
    .write_i   (req_write),
    .addr_i    (req_write ? GPIO_OUT_ADDR : GPIO_IN_ADDR),
    .wdata_i   ({30'b0, req_val}),
    .pready_i  (PREADY),
    .pslverr_i (PSLVERR),
`ifdef SCCB_SEQ_READBACK_EN
    .prdata_i  (PRDATA),
    .rdata_o   (rdata),
`endif
    .psel_o    (PSEL),
    .penable_o (PENABLE),
    .pwrite_o  (PWRITE),
    .paddr_o   (PADDR),
    .pwdata_o  (PWDATA),
    .cpl_o     (cpl),
    .err_o     (xfer_err)
  );

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign err  = done & err_q;

endmodule

// File: tb/tb_sccb_gpio_sequencer.sv
// Directed bench for sccb_gpio_sequencer with a CoreGPIO-like APB slave model.
module tb_sccb_gpio_sequencer;

  localparam int HC = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        start;
  logic [7:0]  dev_addr, reg_addr, wr_data;
  logic        busy, done, err;
  logic [7:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY = 1'b1;
  logic        PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  sccb_gpio_sequencer #(.HALF_CYC(HC)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .start    (start),
    .dev_addr (dev_addr),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
`ifdef SCCB_SEQ_READBACK_EN
    .PRDATA   (PRDATA),
`endif
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          wq[$];
  int          rd_cnt, bad_addr, done_cnt, psel_after, stall_cyc, stall_bad;
  logic [31:0] stall_data;
  logic [1:0]  last_w = 2'b00;
  int          stall_left = 0;
  int          err_at = -1;
  bit          bad_rd_en = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    wq.delete();
    rd_cnt = 0; bad_addr = 0; done_cnt = 0; psel_after = 0;
    stall_cyc = 0; stall_bad = 0;
  endtask

  // Transfer monitor, sampling the values that complete at this edge.
  always @(posedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (PREADY) begin
        if (PWRITE) begin
          wq.push_back(int'(PWDATA));
          last_w = PWDATA[1:0];
          if (PADDR !== 8'hA0) bad_addr++;
        end else begin
          rd_cnt++;
          if (PADDR !== 8'h90) bad_addr++;
        end
      end else begin
        if (stall_cyc == 0) stall_data = PWDATA;
        else if (PWDATA !== stall_data || PADDR !== 8'hA0) stall_bad++;
        stall_cyc++;
      end
    end
    if (done) done_cnt++;
    if (PSEL && done_cnt > 0) psel_after++;
  end

  // Slave response: stalls and errors keyed on the number of writes completed so far.
  always @(negedge PCLK) begin
    PREADY  = 1'b1;
    PSLVERR = 1'b0;
    if (PSEL && PENABLE && PWRITE) begin
      if (wq.size() == 4 && stall_left > 0) begin
        PREADY = 1'b0;
        stall_left--;
      end
      if (wq.size() == err_at) PSLVERR = 1'b1;
    end
    PRDATA = {30'b0, (bad_rd_en && wq.size() == 4) ? 2'b00 : last_w};
  end

  task automatic check_idle(input string tag);
    check_val({tag, "_busy"},    busy,    0);
    check_val({tag, "_done"},    done,    0);
    check_val({tag, "_err"},     err,     0);
    check_val({tag, "_psel"},    PSEL,    0);
    check_val({tag, "_penable"}, PENABLE, 0);
    check_val({tag, "_pwrite"},  PWRITE,  0);
    check_val({tag, "_paddr"},   int'(PADDR),  0);
    check_val({tag, "_pwdata"},  int'(PWDATA), 0);
  endtask

  task automatic run_txn(input string tag, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] w, input int exp_len, input int exp_err,
                         input int exp_wr, input int exp_rd, input bit pulses);
    int          k;
    int          exp_q[$];
    logic [26:0] img;
    img = {d, 1'b1, r, 1'b1, w, 1'b1};
    exp_q.push_back(3);
    exp_q.push_back(1);
    for (int i = 26; i >= 0; i--) begin
      exp_q.push_back(img[i] ? 2 : 0);
      exp_q.push_back(img[i] ? 3 : 1);
    end
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    clr_mon();
    @(negedge PCLK);
    dev_addr = d; reg_addr = r; wr_data = w; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    k = 1;
    check_val({tag, "_setup_psel"},    PSEL,    1);
    check_val({tag, "_setup_penable"}, PENABLE, 0);
    check_val({tag, "_setup_pwrite"},  PWRITE,  1);
    check_val({tag, "_setup_paddr"},   int'(PADDR),  8'hA0);
    check_val({tag, "_setup_pwdata"},  int'(PWDATA), 3);
    check_val({tag, "_setup_busy"},    busy,    1);
    while (!done && k < 2000) begin
      @(negedge PCLK);
      k++;
      if (pulses && (k == 20 || k == 200)) begin
        start = 1'b1; dev_addr = ~d; reg_addr = ~r; wr_data = ~w;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, done, 1);
    check_val({tag, "_latency"},   k, exp_len);
    check_val({tag, "_err"},       err, exp_err);
    check_val({tag, "_busy_at_done"}, busy, 1);
    @(negedge PCLK);
    check_val({tag, "_busy_after"}, busy, 0);
    check_val({tag, "_done_after"}, done, 0);
    repeat (20) @(negedge PCLK);
    check_val({tag, "_done_count"}, done_cnt, 1);
    check_val({tag, "_writes"},     wq.size(), exp_wr);
    check_val({tag, "_reads"},      rd_cnt, exp_rd);
    check_val({tag, "_bad_addr"},   bad_addr, 0);
    check_val({tag, "_psel_after_done"}, psel_after, 0);
    for (int i = 0; i < exp_wr && i < wq.size(); i++)
      check_val($sformatf("%s_wr%0d", tag, i), wq[i], exp_q[i]);
  endtask

  initial begin
    int k;
    PRESET = 1'b1;
    start = 1'b0;
    dev_addr = '0; reg_addr = '0; wr_data = '0;
    repeat (3) @(negedge PCLK);
    check_idle("reset");
    PRESET = 1'b0;
    @(negedge PCLK);

`ifdef SCCB_SEQ_READBACK_EN
    // Reads follow writes 1 (11), 2 (01) and 4 (01); the third read returns 00.
    bad_rd_en = 1'b1;
    run_txn("readback", 8'h42, 8'h12, 8'h80, 27, 1, 4, 3, 1'b0);
    bad_rd_en = 1'b0;
`else
    run_txn("nominal", 8'h42, 8'h12, 8'h80, 59 * (2 + HC) + 1, 0, 59, 0, 1'b0);

    stall_left = 3;
    run_txn("stall", 8'h42, 8'h12, 8'h80, 59 * (2 + HC) + 4, 0, 59, 0, 1'b0);
    check_val("stall_cycles", stall_cyc, 3);
    check_val("stall_stable", stall_bad, 0);
    stall_left = 0;

    // Error on write 10 (step 9): SETUP at 1+6*9, DONE two cycles later.
    err_at = 9;
    run_txn("slverr", 8'h42, 8'h12, 8'h80, 57, 1, 10, 0, 1'b0);
    err_at = -1;

    run_txn("busy_start", 8'h42, 8'h12, 8'h80, 59 * (2 + HC) + 1, 0, 59, 0, 1'b1);

    clr_mon();
    @(negedge PCLK);
    dev_addr = 8'h42; reg_addr = 8'h12; wr_data = 8'h80; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
    k = 0;
    while (wq.size() < 30 && k < 1000) begin
      @(negedge PCLK);
      k++;
    end
    check_val("midrst_reach30", (wq.size() >= 30) ? 1 : 0, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check_idle("midrst");
    PRESET = 1'b0;
    @(negedge PCLK);
    run_txn("post_rst", 8'hA5, 8'h3C, 8'h01, 59 * (2 + HC) + 1, 0, 59, 0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
